// File: rtl/mem_port_arbiter.sv
// Shares one split address/data memory port between instruction fetch and the
// load/store unit: one transaction at a time, round-robin on conflict, sticky watchdog.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_ok,
  input  logic          data_req,
  input  logic [3:0]    data_wen,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_ok,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          timeout_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_I_ADDR = 3'd1;
  localparam logic [2:0] S_I_DATA = 3'd2;
  localparam logic [2:0] S_D_ADDR = 3'd3;
  localparam logic [2:0] S_D_DATA = 3'd4;

  localparam int             CW    = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  C_MAX = CW'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic          w_grant_inst;
  logic          w_grant_data;
  logic          r_last_data;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_wstrb;
  logic [DW-1:0] r_wdata;
  logic          r_wr;
  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;

  // Next-state and grant selection; on conflict the requester not served last wins.
  always_comb begin
    w_next_state = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (inst_req && data_req) begin
          if (r_last_data) begin
            w_grant_inst = 1'b1;
          end else begin
            w_grant_data = 1'b1;
          end
        end else if (data_req) begin
          w_grant_data = 1'b1;
        end else if (inst_req) begin
          w_grant_inst = 1'b1;
        end else begin
          w_grant_inst = 1'b0;
        end
        if (w_grant_data) begin
          w_next_state = S_D_ADDR;
        end else if (w_grant_inst) begin
          w_next_state = S_I_ADDR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_I_ADDR: begin
        if (mem_addr_ok) w_next_state = S_I_DATA;
        else             w_next_state = S_I_ADDR;
      end
      S_I_DATA: begin
        if (mem_data_ok) w_next_state = S_IDLE;
        else             w_next_state = S_I_DATA;
      end
      S_D_ADDR: begin
        if (mem_addr_ok) w_next_state = S_D_DATA;
        else             w_next_state = S_D_ADDR;
      end
      S_D_DATA: begin
        if (mem_data_ok) w_next_state = S_IDLE;
        else             w_next_state = S_D_DATA;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, grant history and the transaction latched at grant time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last_data <= 1'b0;
      r_addr      <= {AW{1'b0}};
      r_wstrb     <= 4'b0000;
      r_wdata     <= {DW{1'b0}};
      r_wr        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_data) begin
        r_last_data <= 1'b1;
        r_addr      <= data_addr;
        r_wstrb     <= data_wen;
        r_wdata     <= data_wdata;
        r_wr        <= |data_wen;
      end else if (w_grant_inst) begin
        r_last_data <= 1'b0;
        r_addr      <= inst_addr;
        r_wstrb     <= 4'b0000;
        r_wdata     <= {DW{1'b0}};
        r_wr        <= 1'b0;
      end else begin
        r_last_data <= r_last_data;
      end
    end
  end

  // Watchdog: counts cycles in the current wait state, saturates, never aborts the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= {CW{1'b0}};
      r_timeout_err <= 1'b0;
    end else begin
      if (w_next_state != r_state) begin
        r_cnt <= {CW{1'b0}};
      end else if ((r_state != S_IDLE) && (r_cnt != C_MAX)) begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
      if ((r_state != S_IDLE) && (r_cnt == C_MAX)) begin
        r_timeout_err <= 1'b1;
      end else begin
        r_timeout_err <= r_timeout_err;
      end
    end
  end

  assign mem_req     = (r_state == S_I_ADDR) || (r_state == S_D_ADDR);
  assign mem_wr      = r_wr;
  assign mem_wstrb   = r_wstrb;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign inst_ok     = (r_state == S_I_DATA) && mem_data_ok;
  assign data_ok     = (r_state == S_D_DATA) && mem_data_ok;
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued requesters, a scripted memory
// responder, and a monitor comparing address phases and completions against expectations.
module tb_mem_port_arbiter;

  typedef struct { logic [31:0] addr; logic [3:0] wen; logic [31:0] wdata; } req_t;
  typedef struct { logic wr; logic [3:0] strb; logic [31:0] addr; logic [31:0] wdata; } aph_t;
  typedef struct { logic is_data; logic [31:0] rdata; } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_ok, data_req, data_ok;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wen, mem_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  req_t iq[$];
  req_t dq[$];
  aph_t exp_a[$];
  rsp_t exp_r[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int i_issue_cyc = 0;
  int n_data_ok = 0;
  int addr_wait = 0;
  int data_wait = 0;
  bit never_ack = 1'b0;
  bit noise = 1'b0;
  bit d_drop = 1'b0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ok(data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ea(input logic wr, input logic [3:0] strb, input logic [31:0] a, input logic [31:0] wd);
    aph_t x;
    x.wr = wr; x.strb = strb; x.addr = a; x.wdata = wd;
    exp_a.push_back(x);
  endtask

  task automatic er(input logic is_data, input logic [31:0] rd);
    rsp_t x;
    x.is_data = is_data; x.rdata = rd;
    exp_r.push_back(x);
  endtask

  task automatic pi(input logic [31:0] a);
    req_t x;
    x.addr = a; x.wen = 4'b0000; x.wdata = 32'h0;
    iq.push_back(x);
  endtask

  task automatic pd(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd);
    req_t x;
    x.addr = a; x.wen = wen; x.wdata = wd;
    dq.push_back(x);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && !inst_req && !data_req && exp_a.size() == 0 && exp_r.size() == 0 &&
          iq.size() == 0 && dq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {95'd0, ok}, 96'd1);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C01_1234;
    else                    return a ^ 32'hFFFF_0000;
  endfunction

  // Instruction requester: holds req until ok, then drops or re-issues.
  initial begin
    bit seen;
    req_t r;
    inst_req = 1'b0; inst_addr = 32'h0;
    forever begin
      @(negedge clk); seen = inst_ok;
      @(posedge clk); #1;
      if (seen) inst_req = 1'b0;
      if (!inst_req && iq.size() > 0) begin
        r = iq.pop_front();
        inst_addr = r.addr; inst_req = 1'b1; i_issue_cyc = cyc;
      end
    end
  end

  // Data requester; d_drop forces req low mid-transaction.
  initial begin
    bit seen;
    req_t r;
    data_req = 1'b0; data_wen = 4'b0000; data_addr = 32'h0; data_wdata = 32'h0;
    forever begin
      @(negedge clk); seen = data_ok;
      @(posedge clk); #1;
      if (seen) data_req = 1'b0;
      if (d_drop) begin
        data_req = 1'b0;
      end else if (!data_req && dq.size() > 0) begin
        r = dq.pop_front();
        data_addr = r.addr; data_wen = r.wen; data_wdata = r.wdata; data_req = 1'b1;
      end
    end
  end

  // Memory responder with programmable stalls, spurious data_ok and a hung-bus mode.
  initial begin
    int phase, cnt;
    logic [31:0] lat;
    phase = 0; cnt = 0; lat = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      if (!rst) begin
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (mem_req) begin
          if (!never_ack && cnt >= addr_wait) begin
            mem_addr_ok = 1'b1; phase = 1; cnt = 0; lat = mem_addr;
          end else begin
            cnt++;
            if (noise) begin mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
          end
        end
      end else begin
        if (cnt >= data_wait) begin
          mem_data_ok = 1'b1; mem_rdata = mem_val(lat); phase = 0; cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: checks every address-phase cycle and every completion against the scoreboard.
  initial begin
    aph_t a;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_req) begin
          if (exp_a.size() == 0) begin
            chk("unexpected_mem_req", {64'd0, mem_addr}, 96'd0);
          end else begin
            a = exp_a[0];
            chk(mem_addr_ok ? "aph_accept" : "aph_stall",
                {27'd0, mem_wr, mem_wstrb, mem_addr, (mem_wr ? mem_wdata : 32'h0)},
                {27'd0, a.wr, a.strb, a.addr, (a.wr ? a.wdata : 32'h0)});
            if (mem_addr_ok) void'(exp_a.pop_front());
          end
        end
        if (data_ok) n_data_ok++;
        if (inst_ok || data_ok) begin
          if (exp_r.size() == 0) begin
            chk("unexpected_ok", {94'd0, inst_ok, data_ok}, 96'd0);
          end else begin
            r = exp_r.pop_front();
            chk("rsp_port", {94'd0, inst_ok, data_ok}, r.is_data ? 96'd1 : 96'd2);
            chk("rsp_rdata", {64'd0, (r.is_data ? data_rdata : inst_rdata)}, {64'd0, r.rdata});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench hung");
  end

  initial begin
    bit got;
    int dok0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {91'd0, mem_req, busy, inst_ok, data_ok, timeout_err}, 96'd0);
    rst = 1'b1;

    // Single fetch, zero-wait memory.
    ea(1'b0, 4'b0000, 32'hBFC0_0000, 32'h0); er(1'b0, 32'h3C01_1234); pi(32'hBFC0_0000);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (inst_ok) begin got = 1'b1; break; end
    end
    chk("fetch_seen", {95'd0, got}, 96'd1);
    chk("fetch_latency", 96'(cyc - i_issue_cyc), 96'd2);
    wait_done("fetch_done", 20);

    // Store with three stalled address cycles.
    addr_wait = 3;
    ea(1'b1, 4'b0100, 32'h8000_0002, 32'hABAB_ABAB); er(1'b1, 32'h7FFF_0002);
    pd(32'h8000_0002, 4'b0100, 32'hABAB_ABAB);
    wait_done("store_done", 30);
    addr_wait = 0;

    // Both requesters from reset: data first, then strict alternation.
    rst = 1'b0;
    ea(1'b0, 4'b0000, 32'h8000_0010, 32'h0);        er(1'b1, 32'h7FFF_0010);
    ea(1'b0, 4'b0000, 32'h0040_0010, 32'h0);        er(1'b0, 32'hFFBF_0010);
    ea(1'b1, 4'b1111, 32'h8000_0020, 32'h1122_3344); er(1'b1, 32'h7FFF_0020);
    ea(1'b0, 4'b0000, 32'h0040_0014, 32'h0);        er(1'b0, 32'hFFBF_0014);
    ea(1'b1, 4'b0010, 32'h8000_0031, 32'h5555_5555); er(1'b1, 32'h7FFF_0031);
    ea(1'b0, 4'b0000, 32'h0040_0018, 32'h0);        er(1'b0, 32'hFFBF_0018);
    pd(32'h8000_0010, 4'b0000, 32'h0); pd(32'h8000_0020, 4'b1111, 32'h1122_3344);
    pd(32'h8000_0031, 4'b0010, 32'h5555_5555);
    pi(32'h0040_0010); pi(32'h0040_0014); pi(32'h0040_0018);
    repeat (3) @(negedge clk);
    chk("conflict_reqs_in_reset", {93'd0, inst_req, data_req, mem_req}, 96'd6);
    rst = 1'b1;
    wait_done("conflict_done", 80);

    // Reset during D_DATA abandons the load; the next fetch starts clean.
    ea(1'b0, 4'b0000, 32'h8000_0100, 32'h0); pd(32'h8000_0100, 4'b0000, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr_ok) begin got = 1'b1; break; end
    end
    chk("reset_txn_accepted", {95'd0, got}, 96'd1);
    @(posedge clk); #2;
    chk("pre_reset_data_ok", {95'd0, data_ok}, 96'd1);
    d_drop = 1'b1;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {92'd0, mem_req, busy, data_ok, inst_ok}, 96'd0);
    ea(1'b0, 4'b0000, 32'h0040_0000, 32'h0); er(1'b0, 32'hFFBF_0000); pi(32'h0040_0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_done("post_reset_fetch", 30);
    d_drop = 1'b0;

    // Spurious data_ok in D_ADDR, requester drops req in D_DATA.
    noise = 1'b1; addr_wait = 2; data_wait = 2;
    dok0 = n_data_ok;
    ea(1'b0, 4'b0000, 32'h8000_0040, 32'h0); er(1'b1, 32'h7FFF_0040);
    pd(32'h8000_0040, 4'b0000, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr_ok) begin got = 1'b1; break; end
    end
    chk("noise_txn_accepted", {95'd0, got}, 96'd1);
    d_drop = 1'b1;
    wait_done("noise_done", 30);
    chk("noise_data_ok_count", 96'(n_data_ok - dok0), 96'd1);
    d_drop = 1'b0; noise = 1'b0; addr_wait = 0; data_wait = 0;

    // Watchdog with the bus hung in I_ADDR.
    chk("wd_clear_before", {95'd0, timeout_err}, 96'd0);
    never_ack = 1'b1;
    ea(1'b0, 4'b0000, 32'hBFC0_0004, 32'h0); er(1'b0, 32'h403F_0004); pi(32'hBFC0_0004);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) begin got = 1'b1; break; end
    end
    chk("wd_mem_req_seen", {95'd0, got}, 96'd1);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (k == 7)  chk("wd_not_yet", {95'd0, timeout_err}, 96'd0);
      if (k == 9)  chk("wd_set_req_held", {94'd0, timeout_err, mem_req}, 96'd3);
      if (k == 12) chk("wd_still_waiting", {94'd0, timeout_err, mem_req}, 96'd3);
    end
    never_ack = 1'b0;
    wait_done("wd_completion", 20);
    chk("wd_sticky", {95'd0, timeout_err}, 96'd1);
    rst = 1'b0;
    #1;
    chk("wd_cleared_by_reset", {94'd0, timeout_err, busy}, 96'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
